// File: rtl/updi_pkg.sv
// ----------------------------------------------------------------------------
// updi_pkg
// Shared definitions for the UPDI physical layer.
//   updi_bridge_mode : mode selected by the bridge controller
//   UPDI_FRAME_BITS  : bits per frame (start + 8 data + parity + 2 stop)
//   UPDI_STOP_BITS   : stop bits per frame
// ----------------------------------------------------------------------------
package updi_pkg;

    typedef enum logic [1:0] {
        UPDI_BRIDGE_MODE_IDLE  = 2'd0,
        UPDI_BRIDGE_MODE_BREAK = 2'd1,
        UPDI_BRIDGE_MODE_TX    = 2'd2,
        UPDI_BRIDGE_MODE_RX    = 2'd3
    } updi_bridge_mode;

    localparam int UPDI_FRAME_BITS = 12;
    localparam int UPDI_STOP_BITS  = 2;

endpackage

// File: rtl/updi_bit_timer.sv
// ----------------------------------------------------------------------------
// updi_bit_timer
// Free-running bit-period counter shared by the TX and RX paths.
//   clk, rst  : system clock, asynchronous active-high reset
//   restart   : forces the counter to 0 on the next cycle (start of a frame)
//   half_stb  : high in the cycle CLK_DIV/2 cycles after the restart cycle
//               (mid-bit sample point), repeating every CLK_DIV cycles
//   full_stb  : high in the last cycle of each bit period
// ----------------------------------------------------------------------------
module updi_bit_timer #(
    parameter int CLK_DIV = 64,
    parameter int DIV_W   = $clog2(CLK_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic half_stb,
    output logic full_stb
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] CNT_HALF = DIV_W'(CLK_DIV / 2 - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q + 1'b1;
        if (restart || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_stb = (cnt_q == CNT_HALF);
    assign full_stb = (cnt_q == CNT_LAST);

endmodule

// File: rtl/updi_bridge.sv
// ----------------------------------------------------------------------------
// updi_bridge
// Single-wire UPDI physical layer between the command sequencer and the pad.
// Frames: 1 start, 8 data LSB-first, even parity, 2 stop bits; CLK_DIV
// system clocks per bit.
//   bridge_mode          : IDLE (release), BREAK (hold low), TX, RX
//   tx_data/valid/ready  : byte handshake into the serializer
//   tx_busy              : TX frame in progress
//   rx_data/valid        : received byte with one-cycle valid pulse
//   rx_parity_err        : parity mismatch on the pulsed frame
//   rx_frame_err         : a stop bit sampled low on the pulsed frame
//   updi_in              : asynchronous pad input
//   updi_out/updi_oe     : pad output value and drive enable
// All outputs are registered.
// ----------------------------------------------------------------------------
module updi_bridge
    import updi_pkg::*;
#(
    parameter int CLK_DIV = 64,
    parameter int DIV_W   = $clog2(CLK_DIV)
) (
    input  logic            clk,
    input  logic            rst,
    input  updi_bridge_mode bridge_mode,
    input  logic [7:0]      tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic            tx_busy,
    output logic [7:0]      rx_data,
    output logic            rx_valid,
    output logic            rx_parity_err,
    output logic            rx_frame_err,
    input  logic            updi_in,
    output logic            updi_out,
    output logic            updi_oe
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TX_START,
        S_TX_DATA,
        S_TX_PAR,
        S_TX_STOP,
        S_RX_START,
        S_RX_DATA,
        S_RX_PAR,
        S_RX_STOP
    } state_t;

    // Frame bit positions: 0 start, 1..8 data, 9 parity, 10..11 stop.
    localparam logic [3:0] POS_DATA_LAST = 4'(UPDI_FRAME_BITS - UPDI_STOP_BITS - 2);
    localparam logic [3:0] POS_LAST      = 4'(UPDI_FRAME_BITS - 1);

    state_t          state_q, state_d;
    updi_bridge_mode mode_q;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            tx_par_q, tx_par_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_par_q, rx_par_d;
    logic            rx_stop1_q, rx_stop1_d;
    logic            sync1_q, rx_s_q, rx_prev_q;

    logic            tx_ready_q, tx_ready_d;
    logic            tx_busy_q, tx_busy_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_perr_q, rx_perr_d;
    logic            rx_ferr_q, rx_ferr_d;
    logic            updi_out_q, updi_out_d;
    logic            updi_oe_q, updi_oe_d;

    logic            restart;
    logic            half_stb, full_stb;
    logic            mode_change;
    logic            rx_fall;
    logic            tx_bit;
    logic [2:0]      tx_idx;

    updi_bit_timer #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .half_stb (half_stb),
        .full_stb (full_stb)
    );

    assign mode_change = (bridge_mode != mode_q);
    assign rx_fall     = rx_prev_q & ~rx_s_q;

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        tx_byte_d  = tx_byte_q;
        tx_par_d   = tx_par_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_stop1_d = rx_stop1_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        restart    = 1'b0;

        // A mode change wins over any handshake or start edge in the same cycle.
        if (mode_change) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bridge_mode == UPDI_BRIDGE_MODE_TX && tx_valid && tx_ready_q) begin
                        state_d   = S_TX_START;
                        tx_byte_d = tx_data;
                        tx_par_d  = ^tx_data;
                        bit_d     = 4'd0;
                        restart   = 1'b1;
                    end else if (bridge_mode == UPDI_BRIDGE_MODE_RX && rx_fall) begin
                        state_d = S_RX_START;
                        bit_d   = 4'd0;
                        restart = 1'b1;
                    end
                end
                S_TX_START: if (full_stb) begin
                    state_d = S_TX_DATA;
                    bit_d   = 4'd1;
                end
                S_TX_DATA: if (full_stb) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == POS_DATA_LAST) state_d = S_TX_PAR;
                end
                S_TX_PAR: if (full_stb) begin
                    bit_d   = bit_q + 4'd1;
                    state_d = S_TX_STOP;
                end
                S_TX_STOP: if (full_stb) begin
                    if (bit_q == POS_LAST) state_d = S_IDLE;
                    else                   bit_d   = bit_q + 4'd1;
                end
                S_RX_START: if (half_stb) begin
                    // Line back high at mid start bit: treat the edge as a glitch.
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RX_DATA;
                        bit_d   = 4'd1;
                    end
                end
                S_RX_DATA: if (half_stb) begin
                    rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                    bit_d      = bit_q + 4'd1;
                    if (bit_q == POS_DATA_LAST) state_d = S_RX_PAR;
                end
                S_RX_PAR: if (half_stb) begin
                    rx_par_d = rx_s_q;
                    bit_d    = bit_q + 4'd1;
                    state_d  = S_RX_STOP;
                end
                S_RX_STOP: if (half_stb) begin
                    if (bit_q == POS_LAST) begin
                        state_d    = S_IDLE;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                        rx_perr_d  = (^rx_shift_q) != rx_par_q;
                        rx_ferr_d  = ~rx_stop1_q | ~rx_s_q;
                    end else begin
                        rx_stop1_d = rx_s_q;
                        bit_d      = bit_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Registered outputs are derived from the next state so they line up
        // with the state register.
        tx_idx = 3'(bit_d - 4'd1);
        case (state_d)
            S_TX_START: tx_bit = 1'b0;
            S_TX_DATA:  tx_bit = tx_byte_d[tx_idx];
            S_TX_PAR:   tx_bit = tx_par_d;
            default:    tx_bit = 1'b1;
        endcase

        tx_ready_d = (bridge_mode == UPDI_BRIDGE_MODE_TX) && (state_d == S_IDLE);
        tx_busy_d  = (state_d == S_TX_START) || (state_d == S_TX_DATA) ||
                     (state_d == S_TX_PAR)   || (state_d == S_TX_STOP);

        case (bridge_mode)
            UPDI_BRIDGE_MODE_BREAK: begin
                updi_oe_d  = 1'b1;
                updi_out_d = 1'b0;
            end
            UPDI_BRIDGE_MODE_TX: begin
                updi_oe_d  = 1'b1;
                updi_out_d = tx_bit;
            end
            default: begin
                updi_oe_d  = 1'b0;
                updi_out_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the synchronizer resets to the idle-high line level so
            // reset release is never mistaken for a start edge.
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= S_IDLE;
            mode_q     <= UPDI_BRIDGE_MODE_IDLE;
            bit_q      <= 4'd0;
            tx_byte_q  <= 8'h00;
            tx_par_q   <= 1'b0;
            rx_shift_q <= 8'h00;
            rx_par_q   <= 1'b0;
            rx_stop1_q <= 1'b1;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            updi_out_q <= 1'b1;
            updi_oe_q  <= 1'b0;
        end else begin
            sync1_q    <= updi_in;
            rx_s_q     <= sync1_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            mode_q     <= bridge_mode;
            bit_q      <= bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_par_q   <= tx_par_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_stop1_q <= rx_stop1_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            updi_out_q <= updi_out_d;
            updi_oe_q  <= updi_oe_d;
        end
    end

    assign tx_ready      = tx_ready_q;
    assign tx_busy       = tx_busy_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign updi_out      = updi_out_q;
    assign updi_oe       = updi_oe_q;

endmodule

// File: tb/tb_updi_bridge.sv
// ----------------------------------------------------------------------------
// tb_updi_bridge
// Directed bench for updi_bridge with CLK_DIV=8. Inputs change 1 time unit
// after a rising edge; outputs are read at the same point or on the falling
// edge by the rx monitor.
// ----------------------------------------------------------------------------
module tb_updi_bridge;
    import updi_pkg::*;

    localparam int DIV = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    updi_bridge_mode bridge_mode = UPDI_BRIDGE_MODE_IDLE;
    logic [7:0]      tx_data = 8'h00;
    logic            tx_valid = 1'b0;
    logic            tx_ready, tx_busy;
    logic [7:0]      rx_data;
    logic            rx_valid, rx_parity_err, rx_frame_err;
    logic            updi_in = 1'b1;
    logic            updi_out, updi_oe;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    updi_bridge #(.CLK_DIV(DIV)) dut (
        .clk           (clk),
        .rst           (rst),
        .bridge_mode   (bridge_mode),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_busy       (tx_busy),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .updi_in       (updi_in),
        .updi_out      (updi_out),
        .updi_oe       (updi_oe)
    );

    // rx monitor: counts valid pulses and output-enable cycles
    int         n_valid = 0;
    int         n_oe    = 0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            cap_data = rx_data;
            cap_perr = rx_parity_err;
            cap_ferr = rx_frame_err;
        end
        if (updi_oe) n_oe++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bit 0 is sent first: start, d0..d7, parity, stop1, stop2
    function automatic logic [11:0] make_frame(input logic [7:0] d, input logic par,
                                               input logic s1, input logic s2);
        return {s2, s1, par, d, 1'b0};
    endfunction

    task automatic send_frame(input logic [11:0] bits);
        for (int i = 0; i < UPDI_FRAME_BITS; i++) begin
            updi_in = bits[i];
            tick(DIV);
        end
        updi_in = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, tx_ready, 0);
        check({tag, "_busy"},  tx_busy, 0);
        check({tag, "_data"},  rx_data, 8'h00);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_perr"},  rx_parity_err, 0);
        check({tag, "_ferr"},  rx_frame_err, 0);
        check({tag, "_out"},   updi_out, 1);
        check({tag, "_oe"},    updi_oe, 0);
    endtask

    logic        out_log   [1:100];
    logic        busy_log  [1:100];
    logic        ready_log [1:100];
    logic [11:0] tx_exp;
    int          v0, oe0, busy_cnt, first_ready;

    initial begin
        // ---------------- reset ----------------
        tick(3);
        check_reset_outputs("rst");
        rst = 1'b0;
        tick(2);

        // ---------------- TX 0xA5 ----------------
        bridge_mode = UPDI_BRIDGE_MODE_TX;
        tick(2);
        check("tx_ready_idle", tx_ready, 1);
        check("tx_oe_idle", updi_oe, 1);
        check("tx_out_idle", updi_out, 1);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            out_log[k]   = updi_out;
            busy_log[k]  = tx_busy;
            ready_log[k] = tx_ready;
            tick(1);
        end
        tx_exp = 12'b110101001010;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("tx_a5_bit%0d_first", i), out_log[8*i+1], tx_exp[i]);
            check($sformatf("tx_a5_bit%0d_last", i),  out_log[8*i+8], tx_exp[i]);
        end
        busy_cnt    = 0;
        first_ready = 0;
        for (int k = 1; k <= 100; k++) begin
            if (busy_log[k]) busy_cnt++;
            if (ready_log[k] && first_ready == 0) first_ready = k;
        end
        check("tx_busy_cycles", busy_cnt, 96);
        check("tx_busy_c96", busy_log[96], 1);
        check("tx_busy_c97", busy_log[97], 0);
        check("tx_ready_return", first_ready, 97);

        // ---------------- RX 0x3C good ----------------
        bridge_mode = UPDI_BRIDGE_MODE_RX;
        tick(4);
        v0  = n_valid;
        oe0 = n_oe;
        check("rx_ready_low", tx_ready, 0);
        send_frame(make_frame(8'h3C, 1'b0, 1'b1, 1'b1));
        tick(16);
        check("rx3c_pulses", n_valid - v0, 1);
        check("rx3c_data", cap_data, 8'h3C);
        check("rx3c_perr", cap_perr, 0);
        check("rx3c_ferr", cap_ferr, 0);
        check("rx3c_oe_cycles", n_oe - oe0, 0);

        // ---------------- parity error, then stop2 low ----------------
        v0 = n_valid;
        send_frame(make_frame(8'h01, 1'b0, 1'b1, 1'b1));
        tick(16);
        check("rxperr_pulses", n_valid - v0, 1);
        check("rxperr_data", cap_data, 8'h01);
        check("rxperr_perr", cap_perr, 1);
        check("rxperr_ferr", cap_ferr, 0);
        v0 = n_valid;
        send_frame(make_frame(8'h00, 1'b0, 1'b1, 1'b0));
        tick(16);
        check("rxferr_pulses", n_valid - v0, 1);
        check("rxferr_perr", cap_perr, 0);
        check("rxferr_ferr", cap_ferr, 1);

        // ---------------- glitch then 0x55 ----------------
        v0 = n_valid;
        updi_in = 1'b0;
        tick(3);
        updi_in = 1'b1;
        tick(20);
        check("glitch_pulses", n_valid - v0, 0);
        send_frame(make_frame(8'h55, 1'b0, 1'b1, 1'b1));
        tick(16);
        check("rx55_pulses", n_valid - v0, 1);
        check("rx55_data", cap_data, 8'h55);
        check("rx55_perr", cap_perr, 0);
        check("rx55_ferr", cap_ferr, 0);

        // ---------------- async reset mid-RX frame ----------------
        v0 = n_valid;
        updi_in = 1'b0; tick(DIV);
        updi_in = 1'b1; tick(DIV);
        updi_in = 1'b0; tick(DIV);
        #3 rst = 1'b1;
        #1 check_reset_outputs("arst");
        updi_in = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(10);
        check("arst_pulses", n_valid - v0, 0);
        send_frame(make_frame(8'h96, 1'b0, 1'b1, 1'b1));
        tick(16);
        check("rx96_pulses", n_valid - v0, 1);
        check("rx96_data", cap_data, 8'h96);
        check("rx96_perr", cap_perr, 0);
        check("rx96_ferr", cap_ferr, 0);

        // ---------------- TX -> RX abort at bit 4 of 0xFF ----------------
        bridge_mode = UPDI_BRIDGE_MODE_TX;
        tick(2);
        check("abort_ready", tx_ready, 1);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(36);
        check("abort_pre_busy", tx_busy, 1);
        check("abort_pre_out", updi_out, 1);
        check("abort_pre_oe", updi_oe, 1);
        v0 = n_valid;
        bridge_mode = UPDI_BRIDGE_MODE_RX;
        tick(1);
        check("abort_oe", updi_oe, 0);
        check("abort_busy", tx_busy, 0);
        check("abort_ready_rx", tx_ready, 0);
        tick(120);
        check("abort_pulses", n_valid - v0, 0);

        // ---------------- BREAK / IDLE drive ----------------
        bridge_mode = UPDI_BRIDGE_MODE_BREAK;
        tick(1);
        check("break_oe", updi_oe, 1);
        check("break_out", updi_out, 0);
        tick(20);
        check("break_hold_oe", updi_oe, 1);
        check("break_hold_out", updi_out, 0);
        bridge_mode = UPDI_BRIDGE_MODE_IDLE;
        tick(1);
        check("idle_oe", updi_oe, 0);
        check("idle_out", updi_out, 1);

        // ---------------- incoming BREAK in RX ----------------
        bridge_mode = UPDI_BRIDGE_MODE_RX;
        tick(4);
        v0 = n_valid;
        updi_in = 1'b0;
        tick(200);
        check("inbrk_pulses", n_valid - v0, 1);
        check("inbrk_data", cap_data, 8'h00);
        check("inbrk_perr", cap_perr, 0);
        check("inbrk_ferr", cap_ferr, 1);
        updi_in = 1'b1;
        tick(20);
        check("inbrk_release_pulses", n_valid - v0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/updi_bridge.md
Name: updi_bridge

Overview:
- Single-wire UPDI physical layer; consumes the bridge mode selected by the bridge controller and drives or samples the UPDI pad.
- TX mode: serializes bytes into UPDI frames of 1 start, 8 data LSB-first, even parity and 2 stop bits.
- RX mode: deserializes frames from the pad. BREAK mode holds the line low; IDLE mode releases the line.
- Sits between the UPDI command sequencer (byte handshakes) and the tri-state pad.

Parameters:
- CLK_DIV, 64, system clocks per UPDI bit; minimum 4.
- DIV_W, $clog2(CLK_DIV), width of the bit-timing counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- bridge_mode  input  updi_bridge_mode  IDLE/BREAK/TX/RX select
- tx_data  input  8  byte to transmit
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  bridge accepts tx_data this cycle
- tx_busy  output  1  TX frame in progress
- rx_data  output  8  last received byte
- rx_valid  output  1  one-cycle pulse: rx_data and the error flags are valid
- rx_parity_err  output  1  parity mismatch on the pulsed frame
- rx_frame_err  output  1  either stop bit sampled low on the pulsed frame
- updi_in  input  1  pad input (asynchronous)
- updi_out  output  1  pad output value
- updi_oe  output  1  pad output enable (1 = drive)

Behaviour:
- Reset values: tx_ready=0, tx_busy=0, rx_data=0, rx_valid=0, both error flags=0, updi_out=1, updi_oe=0. Internal FSM returns to S_IDLE.
- All outputs are registered.
- updi_in passes through a 2-flop synchronizer, reset to 1. Every RX timing reference uses the synchronized value.
- Output drive per mode:
  - IDLE: updi_oe=0, updi_out=1.
  - BREAK: updi_oe=1, updi_out=0 for as long as the mode is held.
  - TX: updi_oe=1; updi_out=1 between frames.
  - RX: updi_oe=0.
- FSM states: S_IDLE, S_TX_START, S_TX_DATA, S_TX_PAR, S_TX_STOP, S_RX_START, S_RX_DATA, S_RX_PAR, S_RX_STOP.
- TX path:
  - tx_ready=1 only in TX mode with FSM in S_IDLE.
  - Handshake: tx_valid & tx_ready latches tx_data and computes parity = ^tx_data. Next cycle: S_TX_START, tx_ready=0, tx_busy=1.
  - Each bit is held exactly CLK_DIV cycles. Sequence: start=0, d0..d7, parity, stop=1, stop=1. Frame length is 12*CLK_DIV cycles.
  - After the second stop bit: back to S_IDLE, tx_busy=0, tx_ready=1 on the following cycle.
  - Back-to-back throughput is one byte per 12*CLK_DIV+1 cycles.
- RX path:
  - In RX mode and S_IDLE, a synchronized 1->0 transition enters S_RX_START.
  - At CLK_DIV/2 (integer division) the line is resampled. If high, it is a glitch: return to S_IDLE with no pulse.
  - Otherwise data bits are sampled every CLK_DIV cycles at mid-bit, LSB first, then parity, then stop1 and stop2.
  - One cycle after the stop2 sample: rx_valid=1 for exactly one cycle. rx_data is updated. rx_parity_err = (^data != parity bit). rx_frame_err = (stop1==0 | stop2==0).
  - A frame error still pulses rx_valid. The next falling edge is accepted one cycle after the pulse, so there is no 2-stop idle requirement.
  - A line held low in RX mode (incoming BREAK) yields data=0x00, parity_err=0, frame_err=1. No new start is detected until the line returns high.
- Mode change mid-frame:
  - Any change of bridge_mode aborts the frame in progress. FSM is in S_IDLE on the next cycle.
  - An aborted RX frame produces no rx_valid. An aborted TX byte is dropped and tx_busy clears.
  - Pad drive follows the new mode from the cycle after the change.
- Simultaneous events: the mode change takes priority over a tx_valid handshake and over a start-edge detect in the same cycle.
- Asynchronous rst mid-frame: all state and outputs return to reset values immediately.

Decomposition:
- Shared package (updi_pkg): updi_bridge_mode enum (UPDI_BRIDGE_MODE_IDLE, _BREAK, _TX, _RX; 2-bit), UPDI_FRAME_BITS=12, UPDI_STOP_BITS=2.
- Bridge FSM state enum is local to this module.
- One sub-module: updi_bit_timer. It takes a CLK_DIV counter with restart input and produces half-bit and full-bit strobes; TX and RX share it.

Test Plan (CLK_DIV=8):
- TX byte 0xA5 in TX mode -> updi_out reads 0,1,0,1,0,0,1,0,1,0(par),1,1, each bit 8 cycles. tx_busy is high for 96 cycles. tx_ready returns on cycle 97.
- RX frame 0x3C, parity 0, good stops -> one rx_valid pulse with rx_data=0x3C and both error flags 0. updi_oe stays 0 throughout.
- RX frame 0x01 with parity 0 (wrong), and a second frame with stop2=0 -> first pulse parity_err=1; second pulse frame_err=1.
- 3-cycle low glitch on updi_in in RX mode -> no rx_valid; a following valid 0x55 frame is received correctly.
- Mode switched TX->RX at bit 4 of a 0xFF frame -> updi_oe=0 on the next cycle, tx_busy=0, no rx_valid. BREAK mode drives updi_oe=1, updi_out=0.
- rst asserted mid-RX frame -> outputs return to reset values asynchronously. After release, a new 0x96 frame is received with correct data.
